// File: rtl/i2c_reg_table_seq.sv
// Register-table sequencer: walks a ROM of write / delay / read-verify / end
// entries, drives a one-shot I2C transaction engine, retries failures, then releases.
module i2c_reg_table_seq #(
  parameter logic [7:0] SLAVE_ADDR  = 8'h1C,
  parameter int         REG_W       = 16,
  parameter int         DATA_W      = 16,
  parameter int         IDX_W       = 6,
  parameter int         SCAL        = 20,
  parameter int         MAX_RETRY   = 3,
  parameter int         RETRY_GAP   = 100,
  parameter int         RELEASE_DLY = 1000
) (
  input  logic                      CLK_400K,
  input  logic                      RESET_N,
  input  logic                      START,
  output logic [IDX_W-1:0]          TBL_IDX,
  input  logic [2+REG_W+DATA_W-1:0] TBL_ENTRY,
  output logic                      M_GO,
  output logic                      M_RW,
  output logic [7:0]                M_SLAVE_ADDR,
  output logic [REG_W-1:0]          M_REG,
  output logic [DATA_W-1:0]         M_WDATA,
  input  logic                      M_DONE,
  input  logic                      M_ACK_OK,
  input  logic [DATA_W-1:0]         M_RDATA,
  output logic                      BUSY,
  output logic                      CONFIG_RELEASE,
  output logic                      ERROR,
  output logic [IDX_W-1:0]          ERR_IDX,
  output logic [DATA_W-1:0]         LAST_RDATA,
  output logic [7:0]                RETRY_CNT
);

  localparam logic [1:0] OP_WR  = 2'b00;
  localparam logic [1:0] OP_DLY = 2'b01;
  localparam logic [1:0] OP_RD  = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WAIT, S_DELAY,
    S_GAP, S_NEXT, S_RELWAIT, S_DONE, S_FAIL
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                rw_q, rw_d;
  logic [7:0]          addr_q, addr_d;
  logic [REG_W-1:0]    reg_q, reg_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [31:0]         cnt_q, cnt_d;
  logic [7:0]          retry_q, retry_d;
  logic [7:0]          rcnt_q, rcnt_d;
  logic                rel_q, rel_d;
  logic                err_q, err_d;
  logic [IDX_W-1:0]    err_idx_q, err_idx_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic [1:0]          ent_op;
  logic [REG_W-1:0]    ent_reg;
  logic [DATA_W-1:0]   ent_data;
  logic                xfer_ok;

  assign ent_op   = TBL_ENTRY[REG_W+DATA_W +: 2];
  assign ent_reg  = TBL_ENTRY[DATA_W +: REG_W];
  assign ent_data = TBL_ENTRY[DATA_W-1:0];
  // A read passes only when the returned data matches the expected DATA field
  assign xfer_ok  = M_ACK_OK && (!rw_q || (M_RDATA == wdata_q));

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    reg_d     = reg_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    retry_d   = retry_q;
    rcnt_d    = rcnt_q;
    rel_d     = rel_q;
    err_d     = err_q;
    err_idx_d = err_idx_q;
    rdata_d   = rdata_q;
    case (state_q)
      S_IDLE, S_DONE, S_FAIL: begin
        if (START) begin
          state_d   = S_FETCH;
          idx_d     = '0;
          rcnt_d    = '0;
          retry_d   = '0;
          err_d     = 1'b0;
          err_idx_d = '0;
          rel_d     = 1'b0;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        addr_d  = SLAVE_ADDR;
        reg_d   = ent_reg;
        wdata_d = ent_data;
        case (ent_op)
          OP_WR:  begin rw_d = 1'b0; state_d = S_ISSUE; end
          OP_RD:  begin rw_d = 1'b1; state_d = S_ISSUE; end
          OP_DLY: begin cnt_d = 32'(ent_data) * 32'(SCAL); state_d = S_DELAY; end
          default: begin cnt_d = '0; state_d = S_RELWAIT; end
        endcase
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (M_DONE) begin
          if (rw_q) rdata_d = M_RDATA;
          if (xfer_ok) begin
            state_d = S_NEXT;
          end else if (retry_q < 8'(MAX_RETRY)) begin
            retry_d = retry_q + 8'd1;
            rcnt_d  = (rcnt_q != 8'hFF) ? rcnt_q + 8'd1 : rcnt_q;
            cnt_d   = '0;
            state_d = S_GAP;
          end else begin
            err_d     = 1'b1;
            err_idx_d = idx_q;
            state_d   = S_FAIL;
          end
        end
      end
      S_GAP: begin
        if (cnt_q + 32'd1 >= 32'(RETRY_GAP)) state_d = S_ISSUE;
        else cnt_d = cnt_q + 32'd1;
      end
      // Down-counter; a zero-length delay still spends one cycle here
      S_DELAY: begin
        if (cnt_q <= 32'd1) begin
          cnt_d   = '0;
          state_d = S_NEXT;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      S_NEXT: begin
        retry_d = '0;
        if (&idx_q) begin
          cnt_d   = '0;
          state_d = S_RELWAIT;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_FETCH;
        end
      end
      S_RELWAIT: begin
        if (cnt_q + 32'd1 >= 32'(RELEASE_DLY)) begin
          rel_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_400K or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      reg_q     <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      retry_q   <= '0;
      rcnt_q    <= '0;
      rel_q     <= 1'b0;
      err_q     <= 1'b0;
      err_idx_q <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      reg_q     <= reg_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      rcnt_q    <= rcnt_d;
      rel_q     <= rel_d;
      err_q     <= err_d;
      err_idx_q <= err_idx_d;
      rdata_q   <= rdata_d;
    end
  end

  assign TBL_IDX        = idx_q;
  assign M_GO           = (state_q == S_ISSUE);
  assign M_RW           = rw_q;
  assign M_SLAVE_ADDR   = addr_q;
  assign M_REG          = reg_q;
  assign M_WDATA        = wdata_q;
  assign BUSY           = !(state_q == S_IDLE || state_q == S_DONE || state_q == S_FAIL);
  assign CONFIG_RELEASE = rel_q;
  assign ERROR          = err_q;
  assign ERR_IDX        = err_idx_q;
  assign LAST_RDATA     = rdata_q;
  assign RETRY_CNT      = rcnt_q;

endmodule

// File: doc/i2c_reg_table_seq.md
I2C_REG_TABLE_SEQ -- requirements
Module: i2c_reg_table_seq

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 8'h1C: 8-bit I2C slave address (write form) driven on M_SLAVE_ADDR.
REQ-002 SHALL have parameter REG_W, default 16: register-address width, 8 or 16.
REQ-003 SHALL have parameter DATA_W, default 16: register-data width, 8 or 16.
REQ-004 SHALL have parameter IDX_W, default 6: table index width; table depth is 2**IDX_W.
REQ-005 SHALL have parameter SCAL, default 20: clock cycles per delay unit.
REQ-006 SHALL have parameter MAX_RETRY, default 3: retries per entry after NACK or verify mismatch.
REQ-007 SHALL have parameter RETRY_GAP, default 100: idle cycles before each retry.
REQ-008 SHALL have parameter RELEASE_DLY, default 1000: cycles from table end to CONFIG_RELEASE.
REQ-009 SHALL have port CLK_400K, input, 1: sole clock; all logic on its rising edge.
REQ-010 SHALL have port RESET_N, input, 1: reset, asynchronous and active-low.
REQ-011 SHALL have port START, input, 1: a level high sampled in IDLE or DONE or FAIL starts a table run.
REQ-012 SHALL have port TBL_IDX, output, IDX_W: table ROM address.
REQ-013 SHALL have port TBL_ENTRY, input, 2+REG_W+DATA_W: {OP[1:0],REG,DATA}, valid one cycle after TBL_IDX changes. OP encoding: 00 write, 01 delay (DATA units), 10 read-verify, 11 end.
REQ-014 SHALL have port M_GO, output, 1: one-cycle request pulse to the I2C transaction engine.
REQ-015 SHALL have port M_RW, output, 1: 0 write, 1 read; held stable from M_GO to M_DONE.
REQ-016 SHALL have ports M_SLAVE_ADDR (output, 8), M_REG (output, REG_W), M_WDATA (output, DATA_W): transaction fields, held stable from M_GO to M_DONE.
REQ-017 SHALL have ports M_DONE (input, 1, one-cycle completion pulse), M_ACK_OK (input, 1, valid with M_DONE), M_RDATA (input, DATA_W, valid with M_DONE).
REQ-018 SHALL have ports BUSY, CONFIG_RELEASE, ERROR (outputs, 1 each), ERR_IDX (output, IDX_W), LAST_RDATA (output, DATA_W), RETRY_CNT (output, 8, total retries this run).

Function
REQ-019 SHALL implement states IDLE, FETCH, DECODE, ISSUE, WAIT, DELAY, GAP, NEXT, RELWAIT, DONE, FAIL.
REQ-020 SHALL perform IDLE->FETCH on START=1, clearing TBL_IDX, RETRY_CNT, ERROR, CONFIG_RELEASE and the per-entry retry count.
REQ-021 SHALL go FETCH->DECODE after exactly one cycle, with TBL_ENTRY sampled in DECODE.
REQ-022 SHALL decode OP in DECODE: write/read-verify->ISSUE; delay->DELAY; end->RELWAIT.
REQ-023 SHALL, in ISSUE, assert M_GO for exactly one cycle, then go to WAIT; M_RW=0 for write, 1 for read-verify.
REQ-024 SHALL ignore M_DONE outside WAIT, and stay in WAIT indefinitely without M_DONE (no timeout).
REQ-025 SHALL treat M_DONE with M_ACK_OK=1 as success for a write; for a read-verify, success additionally requires M_RDATA==DATA. LAST_RDATA SHALL capture M_RDATA on every read completion.
REQ-026 SHALL go WAIT->NEXT on success. On failure, if the per-entry retry count is below MAX_RETRY: increment it and RETRY_CNT (saturating at 255), then GAP; otherwise FAIL.
REQ-027 SHALL wait exactly RETRY_GAP cycles in GAP, then go to ISSUE with the same entry.
REQ-028 SHALL wait exactly DATA*SCAL cycles in DELAY, using a 32-bit counter; DATA=0 goes to NEXT on the following cycle.
REQ-029 SHALL, in NEXT, clear the per-entry retry count. If TBL_IDX is the all-ones value, go to RELWAIT (no wrap); else increment TBL_IDX and go to FETCH.
REQ-030 SHALL hold RELWAIT for RELEASE_DLY cycles, then go to DONE with CONFIG_RELEASE=1.
REQ-031 SHALL, in FAIL, set ERROR=1 and ERR_IDX=TBL_IDX; CONFIG_RELEASE SHALL stay 0.
REQ-032 SHALL assert BUSY in every state except IDLE, DONE and FAIL.
REQ-033 SHALL, on START=1 in DONE or FAIL, restart as in REQ-020; START while BUSY SHALL be ignored.
REQ-034 SHALL drive M_SLAVE_ADDR=SLAVE_ADDR and M_REG/M_WDATA from the REG/DATA fields registered in DECODE.

Reset
REQ-035 SHALL, while RESET_N=0, force state IDLE and all outputs, counters and the delay counter to 0, including mid-transaction; after release SHALL wait for START.

Verification
REQ-036 Table {W 0002/0001, D 16, W 0016/1027, E}, all ACK -> two M_GO pulses with correct fields; 320-cycle gap between them; CONFIG_RELEASE 1000 cycles after the end entry is decoded.
REQ-037 First write NACKed twice, then ACKed -> RETRY_CNT=2, exactly RETRY_GAP cycles before each reissue, run completes.
REQ-038 Read-verify of 0000 expecting 4401; engine returns 4400 on 4 attempts -> FAIL, ERROR=1, ERR_IDX=entry index, LAST_RDATA=4400.
REQ-039 Delay entry with DATA=0, and a 64-entry table with no end entry -> no stall; run ends after index 63 without wrap.
REQ-040 RESET_N low during WAIT and during DELAY -> outputs 0 immediately; the next START reruns from index 0.
